// File: rtl/fifo_dot_product.sv
// fifo_dot_product
//   Pulls LENGTH element pairs from two operand FIFOs (A = matrix row,
//   B = vector), multiply-accumulates them as unsigned values and presents
//   the dot product with a one-cycle done pulse.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start             begin a dot product; only looked at in IDLE
//   a_empty, b_empty  operand FIFO empty flags
//   a_data, b_data    operand FIFO read data, valid the cycle after a pop
//   a_rden, b_rden    pop requests, always asserted together
//   busy              high while in RUN or DRAIN
//   done              one-cycle pulse, result valid in the same cycle
//   result            last completed dot product, held until the next done
module fifo_dot_product #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  a_empty,
  input  logic                  b_empty,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  a_rden,
  output logic                  b_rden,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result
);

  localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH + 1) : 1;
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LENGTH);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LENGTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        issued;
  logic                    pop_vld;   // FIFO data of last cycle's pop is on a_data/b_data
  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH-1:0]    acc_sum;
  logic [2*DATA_WIDTH-1:0] prod;
  logic                    pop;
  logic                    last_pop;

  // Pop decision is combinational so a FIFO going non-empty is used the
  // same cycle; both FIFOs are popped together so pairs never split.
  assign pop      = (state == RUN) && (issued < LEN_C) && !a_empty && !b_empty;
  assign last_pop = pop && (issued == LAST_C);
  assign a_rden   = pop;
  assign b_rden   = pop;

  assign prod    = a_data * b_data;
  assign acc_sum = acc + ACC_WIDTH'(prod);   // wraps modulo 2^ACC_WIDTH

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      issued  <= '0;
      pop_vld <= 1'b0;
      acc     <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      pop_vld <= pop;
      done    <= 1'b0;
      if (pop_vld) acc <= acc_sum;
      case (state)
        IDLE: if (start) begin
          acc    <= '0;
          issued <= '0;
          busy   <= 1'b1;
          state  <= RUN;
        end
        RUN: if (pop) begin
          issued <= issued + 1'b1;
          if (last_pop) state <= DRAIN;
        end
        // The final pair arrives this cycle; fold it straight into result
        // so result is already valid while done is high.
        DRAIN: begin
          result <= acc_sum;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_dot_product.sv
module tb_fifo_dot_product;
  localparam int LEN = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a_empty, b_empty;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_rden, b_rden, busy, done;
  logic [23:0] result;
  logic       a_rden1, b_rden1, busy1, done1;
  logic [15:0] result1;

  always #5 clk = ~clk;

  fifo_dot_product #(.DATA_WIDTH(8), .LENGTH(LEN), .ACC_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_empty(a_empty), .b_empty(b_empty),
    .a_data(a_data), .b_data(b_data), .a_rden(a_rden), .b_rden(b_rden),
    .busy(busy), .done(done), .result(result));

  // Narrow-accumulator copy sees identical inputs; checks wrap behaviour.
  fifo_dot_product #(.DATA_WIDTH(8), .LENGTH(LEN), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .a_empty(a_empty), .b_empty(b_empty),
    .a_data(a_data), .b_data(b_data), .a_rden(a_rden1), .b_rden(b_rden1),
    .busy(busy1), .done(done1), .result(result1));

  // Behavioural operand FIFOs, popped by the 24-bit instance.
  logic [7:0] amem [256];
  logic [7:0] bmem [256];
  logic [7:0] a_wp = '0, a_rp = '0, b_wp = '0, b_rp = '0;
  logic       a_push = 1'b0, b_push = 1'b0, flush = 1'b0;
  logic [7:0] a_wval = '0, b_wval = '0;
  int         cyc = 0;

  assign a_empty = (a_wp == a_rp);
  assign b_empty = (b_wp == b_rp);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (flush) begin
      a_wp <= '0; a_rp <= '0; b_wp <= '0; b_rp <= '0;
    end else begin
      if (a_push) begin amem[a_wp] <= a_wval; a_wp <= a_wp + 8'd1; end
      if (b_push) begin bmem[b_wp] <= b_wval; b_wp <= b_wp + 8'd1; end
      if (a_rden) begin a_data <= amem[a_rp]; a_rp <= a_rp + 8'd1; end
      if (b_rden) begin b_data <= bmem[b_rp]; b_rp <= b_rp + 8'd1; end
    end
  end

  // Scoreboard
  typedef struct {
    logic [23:0] r24;
    logic [15:0] r16;
    int          scyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errs = 0, checks = 0, pops = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_rden || b_rden || a_rden1 || b_rden1) begin
        chk("rden_pair", a_rden, b_rden);
        chk("rden_dut16_match", {a_rden1, b_rden1}, {a_rden, b_rden});
        chk("pop_while_empty", a_empty || b_empty, 0);
        if (a_rden) pops++;
      end
      if (done || done1) begin
        chk("done_pair", done1, done);
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("result24", result, mon_e.r24);
          chk("result16", result1, mon_e.r16);
          chk("pops_per_op", pops, LEN);
          if (mon_e.chk_lat) chk("done_latency", cyc - mon_e.scyc, LEN + 2);
        end
        pops = 0;
      end
    end else pops = 0;
  end

  // Reference: plain sum of products, truncated to the accumulator width
  // (truncation is the modulo 2^W wrap).
  logic [7:0] va [LEN];
  logic [7:0] vb [LEN];
  logic [7:0] s1a [LEN];
  logic [7:0] s1b [LEN];

  function automatic exp_t model(input int scyc, input bit lat);
    exp_t   e;
    longint s = 0;
    for (int i = 0; i < LEN; i++) s += longint'(va[i]) * longint'(vb[i]);
    e.r24 = 24'(s);
    e.r16 = 16'(s);
    e.scyc = scyc;
    e.chk_lat = lat;
    return e;
  endfunction

  task automatic rand_vec();
    for (int i = 0; i < LEN; i++) begin
      va[i] = 8'($urandom);
      vb[i] = 8'($urandom);
    end
  endtask

  task automatic push_pairs();
    for (int i = 0; i < LEN; i++) begin
      @(negedge clk);
      a_push = 1'b1; a_wval = va[i];
      b_push = 1'b1; b_wval = vb[i];
    end
    @(negedge clk);
    a_push = 1'b0; b_push = 1'b0;
  endtask

  // mode 0: both preloaded, 1: A preloaded / B one every 3 cycles,
  // 2: both trickled randomly, 3: data already sitting in the FIFOs.
  // poke pulses start mid-run and on the done cycle.
  task automatic run_op(input int mode, input bit lat, input bit poke);
    int ai, bi, n;
    if (mode == 0) push_pairs();
    else if (mode == 1) begin
      for (int i = 0; i < LEN; i++) begin
        @(negedge clk); a_push = 1'b1; a_wval = va[i];
      end
      @(negedge clk); a_push = 1'b0;
    end else if (mode == 2) @(negedge clk);
    ai = (mode != 2) ? LEN : 0;
    bi = (mode == 0 || mode == 3) ? LEN : 0;
    sb.push_back(model(cyc, lat));
    start = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      start = 1'b0; a_push = 1'b0; b_push = 1'b0;
      if (done) break;
      n++;
      if (n > 300) begin chk("op_timeout", 0, 1); break; end
      if (poke && n == 3) start = 1'b1;
      if (mode == 1 && bi < LEN && (cyc % 3) == 0) begin
        b_push = 1'b1; b_wval = vb[bi]; bi++;
      end
      if (mode == 2) begin
        if (ai < LEN && $urandom_range(0, 2) != 0) begin a_push = 1'b1; a_wval = va[ai]; ai++; end
        if (bi < LEN && $urandom_range(0, 2) != 0) begin b_push = 1'b1; b_wval = vb[bi]; bi++; end
      end
    end
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_a_rden", a_rden, 0);
    chk("rst_b_rden", b_rden, 0);
    chk("rst_result", result, 0);
    chk("rst_result16", result1, 0);
    rst_n = 1'b1;

    // Basic: A=1..8, B=2 -> 72, done at k+LEN+2
    for (int i = 0; i < LEN; i++) begin va[i] = 8'(i + 1); vb[i] = 8'd2; end
    run_op(0, 1, 0);

    // B trickles in every third cycle
    rand_vec();
    run_op(1, 0, 0);

    // All-ones operands: fits in 24 bits, wraps in 16 bits
    for (int i = 0; i < LEN; i++) begin va[i] = 8'hFF; vb[i] = 8'hFF; end
    run_op(0, 1, 0);

    // Ignored starts: two ops' worth of data queued, stray starts must not
    // pull the second set early
    rand_vec();
    for (int i = 0; i < LEN; i++) begin s1a[i] = va[i]; s1b[i] = vb[i]; end
    push_pairs();
    rand_vec();
    push_pairs();
    for (int i = 0; i < LEN; i++) begin
      vb[i] = va[i]; va[i] = s1a[i];
      s1a[i] = vb[i];
    end
    for (int i = 0; i < LEN; i++) begin vb[i] = s1b[i]; end
    // va/vb now hold set 1; s1a holds set-2 A values, rebuild set-2 B below
    run_op(3, 1, 1);
    repeat (3) @(negedge clk);
    chk("poke_idle_busy", busy, 0);
    chk("poke_a_left", 8'(a_wp - a_rp), LEN);
    chk("poke_b_left", 8'(b_wp - b_rp), LEN);
    for (int i = 0; i < LEN; i++) begin
      va[i] = s1a[i];
      vb[i] = bmem[8'(b_rp + 8'(i))];
    end
    run_op(3, 1, 0);

    // Random ops with random stalls on both FIFOs
    for (int t = 0; t < 6; t++) begin
      rand_vec();
      run_op(2, 0, 0);
    end
    rand_vec();
    run_op(0, 1, 0);

    // Mid-operation reset after three pops
    rand_vec();
    push_pairs();
    start = 1'b1;
    n = 0;
    for (int c = 0; c < 50 && n < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (a_rden) n++;
    end
    chk("pre_reset_pops", n, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_a_rden", a_rden, 0);
    chk("midrst_b_rden", b_rden, 0);
    chk("midrst_result", result, 0);
    chk("midrst_result16", result1, 0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("postrst_busy", busy, 0);
    chk("postrst_result", result, 0);
    chk("postrst_a_rden", a_rden, 0);

    // Recovery after reset
    rand_vec();
    run_op(0, 1, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
